// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, presents it to the combinational instruction
// memory and registers the returned word into the IF/ID pipeline register.
// Handles stall, redirect with wrong-path squash and a sticky fault on a
// misaligned redirect target.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_inst,
    output logic [31:0] o_ifid_inst,
    output logic [31:0] o_ifid_pc,
    output logic [31:0] o_ifid_pc4,
    output logic        o_ifid_valid,
    output logic        o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_fault;
    logic [31:0] r_fault_pc;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_ifid_inst_nxt;
    logic [31:0] w_ifid_pc_nxt;
    logic [31:0] w_ifid_pc4_nxt;
    logic        w_ifid_valid_nxt;
    logic        w_fault_nxt;
    logic [31:0] w_fault_pc_nxt;
    logic [31:0] w_fetch_count_nxt;
    logic [31:0] w_pc_plus4;
    logic        w_misaligned;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);

    // FSM state register; reset always returns to BOOT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath-next logic; everything holds unless a branch below changes it.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_ifid_inst_nxt   = r_ifid_inst;
        w_ifid_pc_nxt     = r_ifid_pc;
        w_ifid_pc4_nxt    = r_ifid_pc4;
        w_ifid_valid_nxt  = r_ifid_valid;
        w_fault_nxt       = r_fault;
        w_fault_pc_nxt    = r_fault_pc;
        w_fetch_count_nxt = r_fetch_count;

        case (r_state)
            BOOT: begin
                // No older instruction exists yet, so redirect and stall are ignored here.
                w_state_nxt      = RUN;
                w_ifid_inst_nxt  = NOP_INST;
                w_ifid_valid_nxt = 1'b0;
            end
            RUN: begin
                if (i_redirect_valid && w_misaligned) begin
                    w_state_nxt      = FAULT;
                    w_fault_nxt      = 1'b1;
                    w_fault_pc_nxt   = i_redirect_pc;
                    w_ifid_inst_nxt  = NOP_INST;
                    w_ifid_valid_nxt = 1'b0;
                end else if (i_redirect_valid) begin
                    // Redirect beats stall: the branch is older than the stalled instruction.
                    w_pc_nxt         = i_redirect_pc;
                    w_ifid_inst_nxt  = NOP_INST;
                    w_ifid_valid_nxt = 1'b0;
                end else if (i_stall) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt          = w_pc_plus4;
                    w_ifid_inst_nxt   = i_imem_inst;
                    w_ifid_pc_nxt     = r_pc;
                    w_ifid_pc4_nxt    = w_pc_plus4;
                    w_ifid_valid_nxt  = 1'b1;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                end
            end
            FAULT: begin
                w_ifid_inst_nxt  = NOP_INST;
                w_ifid_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt      = BOOT;
                w_ifid_inst_nxt  = NOP_INST;
                w_ifid_valid_nxt = 1'b0;
            end
        endcase
    end

    // PC, IF/ID register, fault capture and fetch counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc          <= RESET_PC;
            r_ifid_inst   <= NOP_INST;
            r_ifid_pc     <= 32'd0;
            r_ifid_pc4    <= 32'd0;
            r_ifid_valid  <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_pc    <= 32'd0;
            r_fetch_count <= 32'd0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_ifid_inst   <= w_ifid_inst_nxt;
            r_ifid_pc     <= w_ifid_pc_nxt;
            r_ifid_pc4    <= w_ifid_pc4_nxt;
            r_ifid_valid  <= w_ifid_valid_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_pc    <= w_fault_pc_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_ifid_inst   = r_ifid_inst;
    assign o_ifid_pc     = r_ifid_pc;
    assign o_ifid_pc4    = r_ifid_pc4;
    assign o_ifid_valid  = r_ifid_valid;
    assign o_fault       = r_fault;
    assign o_fault_pc    = r_fault_pc;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a word-addressed
// combinational instruction memory model.
module tb_instruction_fetch;

    logic        i_clk;
    logic        i_reset;
    logic        i_stall;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_inst;
    logic [31:0] o_ifid_inst;
    logic [31:0] o_ifid_pc;
    logic [31:0] o_ifid_pc4;
    logic        o_ifid_valid;
    logic        o_fault;
    logic [31:0] o_fault_pc;
    logic [31:0] o_fetch_count;

    logic [31:0] mem [0:1023];

    int compareCount;
    int mismatchCount;

    instruction_fetch dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_stall          (i_stall),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_addr      (o_imem_addr),
        .i_imem_inst      (i_imem_inst),
        .o_ifid_inst      (o_ifid_inst),
        .o_ifid_pc        (o_ifid_pc),
        .o_ifid_pc4       (o_ifid_pc4),
        .o_ifid_valid     (o_ifid_valid),
        .o_fault          (o_fault),
        .o_fault_pc       (o_fault_pc),
        .o_fetch_count    (o_fetch_count)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Combinational instruction memory read, indexed by word.
    always_comb begin
        i_imem_inst = mem[o_imem_addr[11:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic rv, input logic [31:0] rpc);
        i_stall          = stall;
        i_redirect_valid = rv;
        i_redirect_pc    = rpc;
    endtask

    task automatic stepEdge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".addr"},  o_imem_addr,   32'h0);
        checkOutput({tag, ".inst"},  o_ifid_inst,   32'h0000_0013);
        checkOutput({tag, ".pc"},    o_ifid_pc,     32'h0);
        checkOutput({tag, ".pc4"},   o_ifid_pc4,    32'h0);
        checkOutput({tag, ".valid"}, {31'd0, o_ifid_valid}, 32'd0);
        checkOutput({tag, ".fault"}, {31'd0, o_fault}, 32'd0);
        checkOutput({tag, ".fpc"},   o_fault_pc,    32'h0);
        checkOutput({tag, ".count"}, o_fetch_count, 32'd0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;

        // T1: reset and first two fetches
        i_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #12;
        checkResetValues("rst0");
        i_reset = 1'b0;
        stepEdge();
        checkOutput("t1.e1.valid", {31'd0, o_ifid_valid}, 32'd0);
        checkOutput("t1.e1.addr",  o_imem_addr, 32'h0);
        stepEdge();
        checkOutput("t1.e2.inst",  o_ifid_inst, 32'h0050_0093);
        checkOutput("t1.e2.pc",    o_ifid_pc,   32'h0);
        checkOutput("t1.e2.pc4",   o_ifid_pc4,  32'h4);
        checkOutput("t1.e2.valid", {31'd0, o_ifid_valid}, 32'd1);
        stepEdge();
        checkOutput("t1.e3.inst",  o_ifid_inst, 32'h0010_0113);
        checkOutput("t1.e3.pc",    o_ifid_pc,   32'h4);
        checkOutput("t1.e3.count", o_fetch_count, 32'd2);
        checkOutput("t1.e3.addr",  o_imem_addr, 32'h8);

        // T2: three-cycle stall at PC=8
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            stepEdge();
            checkOutput("t2.addr",  o_imem_addr,   32'h8);
            checkOutput("t2.inst",  o_ifid_inst,   32'h0010_0113);
            checkOutput("t2.pc",    o_ifid_pc,     32'h4);
            checkOutput("t2.count", o_fetch_count, 32'd2);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkOutput("t2.rel.pc",    o_ifid_pc,   32'h8);
        checkOutput("t2.rel.inst",  o_ifid_inst, 32'h1000_0002);
        checkOutput("t2.rel.addr",  o_imem_addr, 32'hC);
        checkOutput("t2.rel.count", o_fetch_count, 32'd3);
        stepEdge();
        checkOutput("t3.pre.addr",  o_imem_addr, 32'h10);

        // T3: redirect to 0x40 at PC=0x10
        applyStimulus(1'b0, 1'b1, 32'h40);
        stepEdge();
        checkOutput("t3.addr",  o_imem_addr, 32'h40);
        checkOutput("t3.valid", {31'd0, o_ifid_valid}, 32'd0);
        checkOutput("t3.inst",  o_ifid_inst, 32'h0000_0013);
        checkOutput("t3.pc",    o_ifid_pc,   32'hC);
        checkOutput("t3.count", o_fetch_count, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'hDEAD_BEE1);
        stepEdge();
        checkOutput("t3.nx.pc",    o_ifid_pc,   32'h40);
        checkOutput("t3.nx.valid", {31'd0, o_ifid_valid}, 32'd1);
        checkOutput("t3.nx.inst",  o_ifid_inst, 32'h1000_0010);
        checkOutput("t3.nx.addr",  o_imem_addr, 32'h44);

        // T4: stall and redirect together, redirect wins
        applyStimulus(1'b1, 1'b1, 32'h80);
        stepEdge();
        checkOutput("t4.addr",  o_imem_addr, 32'h80);
        checkOutput("t4.valid", {31'd0, o_ifid_valid}, 32'd0);
        checkOutput("t4.inst",  o_ifid_inst, 32'h0000_0013);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkOutput("t4.nx.pc",    o_ifid_pc,   32'h80);
        checkOutput("t4.nx.inst",  o_ifid_inst, 32'h1000_0020);
        checkOutput("t4.nx.count", o_fetch_count, 32'd6);

        // T6: async reset mid-cycle while running at PC=0x20
        applyStimulus(1'b0, 1'b1, 32'h20);
        stepEdge();
        checkOutput("t6.pre.addr", o_imem_addr, 32'h20);
        applyStimulus(1'b0, 1'b0, 32'h0);
        #2;
        i_reset = 1'b1;
        #1;
        checkResetValues("t6.rst");
        i_reset = 1'b0;
        // Redirect during BOOT must be ignored
        applyStimulus(1'b0, 1'b1, 32'h100);
        stepEdge();
        checkOutput("t6.boot.addr",  o_imem_addr, 32'h0);
        checkOutput("t6.boot.valid", {31'd0, o_ifid_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkOutput("t6.e2.inst",  o_ifid_inst, 32'h0050_0093);
        checkOutput("t6.e2.count", o_fetch_count, 32'd1);

        // T5: misaligned redirect target enters sticky fault
        applyStimulus(1'b0, 1'b1, 32'h42);
        stepEdge();
        checkOutput("t5.fault", {31'd0, o_fault}, 32'd1);
        checkOutput("t5.fpc",   o_fault_pc, 32'h42);
        checkOutput("t5.addr",  o_imem_addr, 32'h4);
        checkOutput("t5.inst",  o_ifid_inst, 32'h0000_0013);
        applyStimulus(1'b0, 1'b1, 32'h200);
        for (int k = 0; k < 10; k++) begin
            stepEdge();
            checkOutput("t5.hold.addr",  o_imem_addr, 32'h4);
            checkOutput("t5.hold.valid", {31'd0, o_ifid_valid}, 32'd0);
            checkOutput("t5.hold.count", o_fetch_count, 32'd1);
            checkOutput("t5.hold.fault", {31'd0, o_fault}, 32'd1);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        #2;
        i_reset = 1'b1;
        #1;
        checkResetValues("t5.rst");
        i_reset = 1'b0;

        // PC+4 wrap at the top of the address space
        stepEdge();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        stepEdge();
        checkOutput("wrap.addr", o_imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkOutput("wrap.pc",    o_ifid_pc,   32'hFFFF_FFFC);
        checkOutput("wrap.pc4",   o_ifid_pc4,  32'h0);
        checkOutput("wrap.inst",  o_ifid_inst, 32'h1000_03FF);
        checkOutput("wrap.addr2", o_imem_addr, 32'h0);
        checkOutput("wrap.count", o_fetch_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
